// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file datapath.
package regfile_sb_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned ZeroRegAddr  = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Write, read, issue and scoreboard-status signals of the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = regfile_sb_pkg::DefaultDataW,
  parameter int unsigned ADDR_W = regfile_sb_pkg::DefaultAddrW
);

  logic              reg_write;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] Rs;
  logic [ADDR_W-1:0] Rt;
  logic [DATA_W-1:0] Out1;
  logic [DATA_W-1:0] Out2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              rs_busy;
  logic              rt_busy;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output reg_write, Rd, data, Rs, Rt, issue_valid, issue_rd,
    input  Out1, Out2, rs_busy, rt_busy, busy_count
  );

  modport slave (
    input  reg_write, Rd, data, Rs, Rt, issue_valid, issue_rd,
    output Out1, Out2, rs_busy, rt_busy, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer bits with a registered population counter.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              commit_i,
  input  logic [ADDR_W-1:0] commit_rd_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);
  localparam logic [ADDR_W-1:0] ZeroA = ADDR_W'(ZeroRegAddr);

  logic [Depth-1:0] busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             set, inc, dec;

  always_comb begin
    set    = issue_valid_i && rst_ni && !(ZERO_REG && (issue_rd_i == ZeroA));
    // Same-address set and clear keeps the bit: the new producer wins.
    inc    = set && !busy_q[issue_rd_i];
    dec    = commit_i && busy_q[commit_rd_i] && !(set && (issue_rd_i == commit_rd_i));
    busy_d = busy_q;
    if (commit_i) busy_d[commit_rd_i] = 1'b0;
    if (set)      busy_d[issue_rd_i]  = 1'b1;
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs_busy_o = busy_q[rs_i];
    rt_busy_o = busy_q[rt_i];
    if (BYPASS && commit_i && (commit_rd_i == rs_i) && !(set && (issue_rd_i == rs_i))) begin
      rs_busy_o = 1'b0;
    end
    if (BYPASS && commit_i && (commit_rd_i == rt_i) && !(set && (issue_rd_i == rt_i))) begin
      rt_busy_o = 1'b0;
    end
  end

  assign busy_count_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read one-write register file with optional forwarding and a busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroA = ADDR_W'(ZeroRegAddr);

  logic [DATA_W-1:0] regs_q [Depth];
  logic              commit;

  // Writes during reset are ignored, so they must not forward either.
  assign commit = rst_n && bus.reg_write && !(ZERO_REG && (bus.Rd == ZeroA));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[bus.Rd] <= bus.data;
    end
  end

  always_comb begin
    if (ZERO_REG && (bus.Rs == ZeroA)) begin
      bus.Out1 = '0;
    end else if (BYPASS && commit && (bus.Rd == bus.Rs)) begin
      bus.Out1 = bus.data;
    end else begin
      bus.Out1 = regs_q[bus.Rs];
    end
    if (ZERO_REG && (bus.Rt == ZeroA)) begin
      bus.Out2 = '0;
    end else if (BYPASS && commit && (bus.Rd == bus.Rt)) begin
      bus.Out2 = bus.data;
    end else begin
      bus.Out2 = regs_q[bus.Rt];
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .issue_valid_i(bus.issue_valid),
    .issue_rd_i   (bus.issue_rd),
    .commit_i     (commit),
    .commit_rd_i  (bus.Rd),
    .rs_i         (bus.Rs),
    .rt_i         (bus.Rt),
    .rs_busy_o    (bus.rs_busy),
    .rt_busy_o    (bus.rt_busy),
    .busy_count_o (bus.busy_count)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (forwarding and non-forwarding builds).
module tb_regfile_sb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) nbus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (nbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write   = 1'b0;
    bus.issue_valid = 1'b0;
    nbus.reg_write  = 1'b0;
    nbus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Rd = 5'd0; bus.data = '0; bus.Rs = 5'd5; bus.Rt = 5'd7; bus.issue_rd = 5'd0;
    nbus.Rd = 5'd0; nbus.data = '0; nbus.Rs = 5'd5; nbus.Rt = 5'd7; nbus.issue_rd = 5'd0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.Out1 !== 32'h0) begin
      errors++; $display("FAIL reset_out1 got %h want 0", bus.Out1); end
    checks++; if (bus.Out2 !== 32'h0) begin
      errors++; $display("FAIL reset_out2 got %h want 0", bus.Out2); end
    checks++; if (bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL reset_rs_busy got %b want 0", bus.rs_busy); end
    checks++; if (bus.rt_busy !== 1'b0) begin
      errors++; $display("FAIL reset_rt_busy got %b want 0", bus.rt_busy); end
    checks++; if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", bus.busy_count); end
    checks++; if (nbus.Out1 !== 32'h0) begin
      errors++; $display("FAIL reset_nb_out1 got %h want 0", nbus.Out1); end
  endtask

  task automatic test_bypass();
    bus.reg_write = 1'b1; bus.Rd = 5'd1; bus.data = 32'h60C00180; bus.Rs = 5'd1; bus.Rt = 5'd0;
    #1;
    checks++; if (bus.Out1 !== 32'h60C00180) begin
      errors++; $display("FAIL bypass_same_cycle got %h want 60c00180", bus.Out1); end
    checks++; if (bus.Out2 !== 32'h0) begin
      errors++; $display("FAIL bypass_rt_zero got %h want 0", bus.Out2); end
    tick();
    idle();
    #1;
    checks++; if (bus.Out1 !== 32'h60C00180) begin
      errors++; $display("FAIL bypass_stored got %h want 60c00180", bus.Out1); end
  endtask

  task automatic test_zero_reg();
    bus.reg_write = 1'b1; bus.Rd = 5'd0; bus.data = 32'hFFFFFFFF; bus.Rs = 5'd0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    checks++; if (bus.Out1 !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle got %h want 0", bus.Out1); end
    tick();
    idle();
    #1;
    checks++; if (bus.Out1 !== 32'h0) begin
      errors++; $display("FAIL zero_stored got %h want 0", bus.Out1); end
    checks++; if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL zero_count got %0d want 0", bus.busy_count); end
    checks++; if (bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL zero_busy got %b want 0", bus.rs_busy); end
  endtask

  task automatic test_scoreboard();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd2; bus.Rs = 5'd2; bus.Rt = 5'd2;
    tick();
    idle();
    #1;
    checks++; if (bus.rt_busy !== 1'b1) begin
      errors++; $display("FAIL issue_rt_busy got %b want 1", bus.rt_busy); end
    checks++; if (bus.rs_busy !== 1'b1) begin
      errors++; $display("FAIL issue_rs_busy got %b want 1", bus.rs_busy); end
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL issue_count got %0d want 1", bus.busy_count); end
    bus.reg_write = 1'b1; bus.Rd = 5'd2; bus.data = 32'hA5A50002;
    #1;
    checks++; if (bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL commit_bypass_busy got %b want 0", bus.rs_busy); end
    checks++; if (bus.Out2 !== 32'hA5A50002) begin
      errors++; $display("FAIL commit_bypass_out2 got %h want a5a50002", bus.Out2); end
    tick();
    idle();
    #1;
    checks++; if (bus.rt_busy !== 1'b0) begin
      errors++; $display("FAIL commit_rt_busy got %b want 0", bus.rt_busy); end
    checks++; if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL commit_count got %0d want 0", bus.busy_count); end
    checks++; if (bus.Out2 !== 32'hA5A50002) begin
      errors++; $display("FAIL commit_out2 got %h want a5a50002", bus.Out2); end
  endtask

  task automatic test_set_clear_same();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    bus.reg_write = 1'b1; bus.Rd = 5'd3; bus.data = 32'h33; bus.Rs = 5'd3; bus.Rt = 5'd3;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL setclr_count got %0d want 1", bus.busy_count); end
    checks++; if (bus.rs_busy !== 1'b1) begin
      errors++; $display("FAIL setclr_busy got %b want 1", bus.rs_busy); end
    checks++; if (bus.Out1 !== 32'h33) begin
      errors++; $display("FAIL setclr_out1 got %h want 33", bus.Out1); end
    bus.reg_write = 1'b1; bus.Rd = 5'd3; bus.data = 32'h33;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL setclr_release got %0d want 0", bus.busy_count); end
  endtask

  task automatic test_count_rules();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    tick();
    #1;
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL count_first got %0d want 1", bus.busy_count); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL count_reissue got %0d want 1", bus.busy_count); end
    bus.reg_write = 1'b1; bus.Rd = 5'd6; bus.data = 32'h66;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL count_idle_write got %0d want 1", bus.busy_count); end
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    bus.reg_write = 1'b1; bus.Rd = 5'd4; bus.data = 32'h44; bus.Rs = 5'd4; bus.Rt = 5'd5;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL count_swap got %0d want 1", bus.busy_count); end
    checks++; if ({bus.rs_busy, bus.rt_busy} !== 2'b01) begin
      errors++; $display("FAIL count_swap_bits got %b want 01", {bus.rs_busy, bus.rt_busy}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 5; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(i);
      tick();
    end
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd5) begin
      errors++; $display("FAIL mid_pre_count got %0d want 5", bus.busy_count); end
    rst_n = 1'b0;
    bus.reg_write = 1'b1; bus.Rd = 5'd1; bus.data = 32'hDEAD;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    tick();
    rst_n = 1'b1;
    idle();
    bus.Rs = 5'd1; bus.Rt = 5'd2;
    #1;
    checks++; if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL mid_count got %0d want 0", bus.busy_count); end
    checks++; if (bus.Out1 !== 32'h0) begin
      errors++; $display("FAIL mid_out1 got %h want 0", bus.Out1); end
    checks++; if (bus.Out2 !== 32'h0) begin
      errors++; $display("FAIL mid_out2 got %h want 0", bus.Out2); end
    checks++; if (bus.rs_busy !== 1'b0) begin
      errors++; $display("FAIL mid_rs_busy got %b want 0", bus.rs_busy); end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(i);
      tick();
    end
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd31) begin
      errors++; $display("FAIL fill_count got %0d want 31", bus.busy_count); end
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd17;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd31) begin
      errors++; $display("FAIL fill_reissue got %0d want 31", bus.busy_count); end
    bus.reg_write = 1'b1; bus.Rd = 5'd7; bus.data = 32'h77;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_count !== 6'd30) begin
      errors++; $display("FAIL fill_release got %0d want 30", bus.busy_count); end
  endtask

  task automatic test_no_bypass();
    nbus.reg_write = 1'b1; nbus.Rd = 5'd4; nbus.data = 32'h5; nbus.Rs = 5'd4;
    #1;
    checks++; if (nbus.Out1 !== 32'h0) begin
      errors++; $display("FAIL nb_same_cycle got %h want 0", nbus.Out1); end
    tick();
    idle();
    #1;
    checks++; if (nbus.Out1 !== 32'h5) begin
      errors++; $display("FAIL nb_next_cycle got %h want 5", nbus.Out1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_clear_same();
    test_count_rules();
    test_reset_mid();
    test_fill();
    test_no_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
